// File: rtl/adc_spi_scan.sv
// SPI master for an ADC128S022-style converter: divided SCLK, address out on MOSI,
// result in on MISO, tagged with the address sent one frame earlier.
module adc_spi_scan #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 3,
    parameter int NUM_CH    = 8,
    parameter int CLK_DIV   = 4,
    parameter int FRAME_LEN = 16,
    parameter int ADDR_POS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              scan_mode,
    input  logic [ADDR_W-1:0] ch_sel,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] sample_ch,
    output logic              sample_valid,
    output logic              busy
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_LEN - 1);
    localparam logic [BIT_W-1:0]  DATA_FIRST = BIT_W'(FRAME_LEN - DATA_W);
    localparam logic [ADDR_W:0]   CH_LIM     = (ADDR_W + 1)'(NUM_CH);
    localparam logic [ADDR_W-1:0] CH_LAST    = ADDR_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic              r_half;
    logic              r_sclk;
    logic              r_cs_n;
    logic              r_mosi;

    state_t            w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [BIT_W-1:0]  w_bit_next;
    logic              w_half_next;
    logic              w_sclk_next;
    logic              w_cs_n_next;
    logic              w_mosi_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_prev_addr;
    logic [ADDR_W-1:0] r_scan_cnt;
    logic              r_primed;
    logic [DATA_W-1:0] r_shift;
    logic              r_cap_last;
    logic [DATA_W-1:0] r_sample_data;
    logic [ADDR_W-1:0] r_sample_ch;
    logic              r_sample_valid;

    logic              w_last;
    logic              w_rise;
    logic              w_setup_entry;
    logic              w_idle_entry;
    logic [ADDR_W-1:0] w_ch_fixed;
    logic [ADDR_W-1:0] w_addr_hit;

    assign w_last        = (r_cnt == CNT_LAST);
    assign w_rise        = (r_state == S_SHIFT) && !r_half && w_last;
    assign w_setup_entry = (w_state_next == S_SETUP) && (r_state != S_SETUP);
    assign w_idle_entry  = (w_state_next == S_IDLE) && (r_state != S_IDLE);
    assign w_ch_fixed    = ({1'b0, ch_sel} < CH_LIM) ? ch_sel : '0;

    // State register; pin outputs are registered so SCLK/CS_n never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_half  <= 1'b0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_half  <= w_half_next;
            r_sclk  <= w_sclk_next;
            r_cs_n  <= w_cs_n_next;
            r_mosi  <= w_mosi_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_half_next  = r_half;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_bit_next  = '0;
                w_half_next = 1'b0;
                if (enable) w_state_next = S_SETUP;
            end
            S_SETUP: begin
                if (w_last) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_half_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (!w_last) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_next = '0;
                    if (!r_half) begin
                        w_half_next = 1'b1;
                    end else if (r_bit == BIT_LAST) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_bit_next  = r_bit + BIT_W'(1);
                        w_half_next = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (w_last) begin
                    w_cnt_next   = '0;
                    w_state_next = enable ? S_SETUP : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One hit per address bit position; MSB goes out first at ADDR_POS.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_bit
            assign w_addr_hit[gi] = (w_bit_next == BIT_W'(ADDR_POS + gi)) && r_addr[ADDR_W-1-gi];
        end
    endgenerate

    always_comb begin
        w_sclk_next = 1'b1;
        w_cs_n_next = 1'b1;
        w_mosi_next = 1'b0;
        case (w_state_next)
            S_SETUP: w_cs_n_next = 1'b0;
            S_SHIFT: begin
                w_cs_n_next = 1'b0;
                w_sclk_next = w_half_next;
                w_mosi_next = |w_addr_hit;
            end
            default: ;
        endcase
    end

    // Datapath: address selection, MISO capture and the tagged sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= '0;
            r_prev_addr    <= '0;
            r_scan_cnt     <= '0;
            r_primed       <= 1'b0;
            r_shift        <= '0;
            r_cap_last     <= 1'b0;
            r_sample_data  <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_cap_last     <= w_rise && (r_bit == BIT_LAST);
            if (w_setup_entry) begin
                if (scan_mode) begin
                    r_addr     <= r_scan_cnt;
                    r_scan_cnt <= (r_scan_cnt == CH_LAST) ? '0 : r_scan_cnt + ADDR_W'(1);
                end else begin
                    r_addr <= w_ch_fixed;
                end
            end
            if (w_rise && (r_bit >= DATA_FIRST)) begin
                r_shift <= {r_shift[DATA_W-2:0], miso};
            end
            // The data just shifted in was converted for the previous frame's address.
            if (r_cap_last) begin
                if (r_primed) begin
                    r_sample_data  <= r_shift;
                    r_sample_ch    <= r_prev_addr;
                    r_sample_valid <= 1'b1;
                end
                r_primed    <= 1'b1;
                r_prev_addr <= r_addr;
            end
            if (w_idle_entry) begin
                r_primed <= 1'b0;
            end
        end
    end

    assign sclk         = r_sclk;
    assign cs_n         = r_cs_n;
    assign mosi         = r_mosi;
    assign sample_data  = r_sample_data;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != S_IDLE);

endmodule
